// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate with a per-group signed offset.
// Three register stages: product (P), accumulate (A), offset and saturate/wrap (O).
module mac_pipe #(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 8,
    parameter int OFFSET    = -9,
    parameter int ACC_LEN   = 4,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  a,
    input  logic [IN_WIDTH-1:0]  b,
    input  logic                 en,
    input  logic                 last,
    output logic [OUT_WIDTH-1:0] result,
    output logic                 valid,
    output logic                 overflow
);
    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Bits needed to hold v as a two's complement number.
    function automatic int sbits(input int v);
        int m;
        int n;
        m = (v < 0) ? -(v + 1) : v;
        n = 1;
        while (m > 0) begin
            m = m >> 1;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int PW = 2 * IN_WIDTH;
    localparam int AW = PW + $clog2(ACC_LEN + 1);
    localparam int SW = imax(imax(AW + 2, sbits(OFFSET)), OUT_WIDTH + 2) + 1;
    localparam int CW = imax($clog2(ACC_LEN + 1), 1);

    localparam logic signed [SW-1:0] OFFS = SW'(OFFSET);
    localparam logic signed [SW-1:0] MAXV = {{(SW-OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    typedef enum logic {IDLE, ACCUM} state_t;

    // ---- stage P ----
    // cnt counts accepted beats at the input so close is known before the
    // product reaches the accumulator, allowing back-to-back groups.
    logic [PW-1:0] p;
    logic          p_vld;
    logic          p_close;
    logic [CW-1:0] cnt;
    logic          close_in;

    assign close_in = last || (cnt == CW'(ACC_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            p       <= '0;
            p_vld   <= 1'b0;
            p_close <= 1'b0;
            cnt     <= '0;
        end else begin
            p_vld <= en;
            if (en) begin
                p       <= PW'(a) * PW'(b);
                p_close <= close_in;
                cnt     <= close_in ? '0 : cnt + CW'(1);
            end
        end
    end

    // ---- stage A ----
    state_t        state, state_nx;
    logic [AW-1:0] acc, acc_nx;
    logic          fin;

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        if (p_vld) begin
            acc_nx   = (state == ACCUM) ? acc + AW'(p) : AW'(p);
            state_nx = p_close ? IDLE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            fin   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            fin   <= p_vld && p_close;
        end
    end

    // ---- stage O ----
    logic signed [SW-1:0]  s;
    logic                  ovf;
    logic [OUT_WIDTH-1:0]  res_nx;

    always_comb begin
        s   = $signed({{(SW-AW){1'b0}}, acc}) + OFFS;
        ovf = (s < 0) || (s > MAXV);
        if (SATURATE != 0)
            res_nx = (s < 0) ? '0 : (s > MAXV) ? '1 : s[OUT_WIDTH-1:0];
        else
            res_nx = s[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result   <= '0;
            valid    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= fin;
            if (fin) begin
                result   <= res_nx;
                overflow <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_mac_pipe.sv
// Three mac_pipe configurations fed a shared stream; each is checked every
// cycle against a group-sum reference model.
module tb_mac_pipe;
    logic       clk = 1'b0;
    logic       rst, en, last;
    logic [4:0] a, b;

    logic [7:0] r0, r1;
    logic [9:0] r2;
    logic       v0, v1, v2, o0, o1, o2;

    always #5 clk = ~clk;

    mac_pipe u0 (.clk(clk), .rst(rst), .a(a), .b(b), .en(en), .last(last),
                 .result(r0), .valid(v0), .overflow(o0));
    mac_pipe #(.SATURATE(0)) u1 (.clk(clk), .rst(rst), .a(a), .b(b), .en(en), .last(last),
                 .result(r1), .valid(v1), .overflow(o1));
    mac_pipe #(.ACC_LEN(1), .OFFSET(0), .OUT_WIDTH(10)) u2 (.clk(clk), .rst(rst), .a(a), .b(b),
                 .en(en), .last(last), .result(r2), .valid(v2), .overflow(o2));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    endtask

    // model parameters per instance
    int m_len [3] = '{4, 4, 1};
    int m_off [3] = '{-9, -9, 0};
    int m_ow  [3] = '{8, 8, 10};
    int m_sat [3] = '{1, 0, 1};

    // open group sum/length; slot j holds the output due j edges from now
    int gsum [3];
    int gn   [3];
    bit sv   [3][3];
    int sr   [3][3];
    bit so   [3][3];
    int hr   [3];
    bit ho   [3];

    function automatic int obs_res(input int k);
        return (k == 0) ? int'(r0) : (k == 1) ? int'(r1) : int'(r2);
    endfunction
    function automatic int obs_vld(input int k);
        return (k == 0) ? int'(v0) : (k == 1) ? int'(v1) : int'(v2);
    endfunction
    function automatic int obs_ovf(input int k);
        return (k == 0) ? int'(o0) : (k == 1) ? int'(o1) : int'(o2);
    endfunction

    task automatic step(input bit e, input int aa, input int bb, input bit l, input bit r);
        int s, mx;
        en = e; a = aa[4:0]; b = bb[4:0]; last = l; rst = r;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 2; j++) begin
                sv[k][j] = sv[k][j+1]; sr[k][j] = sr[k][j+1]; so[k][j] = so[k][j+1];
            end
            sv[k][2] = 1'b0;
            if (r) begin
                for (int j = 0; j < 3; j++) sv[k][j] = 1'b0;
                gsum[k] = 0; gn[k] = 0; hr[k] = 0; ho[k] = 1'b0;
            end else if (e) begin
                gsum[k] += aa * bb;
                gn[k]++;
                if (l || gn[k] == m_len[k]) begin
                    s  = gsum[k] + m_off[k];
                    mx = (1 << m_ow[k]) - 1;
                    so[k][2] = (s < 0) || (s > mx);
                    if (m_sat[k] != 0) sr[k][2] = (s < 0) ? 0 : (s > mx) ? mx : s;
                    else               sr[k][2] = s & mx;
                    sv[k][2] = 1'b1;
                    gsum[k] = 0; gn[k] = 0;
                end
            end
            if (sv[k][0]) begin hr[k] = sr[k][0]; ho[k] = so[k][0]; end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.valid", k),    obs_vld(k), int'(sv[k][0]));
            chk($sformatf("u%0d.result", k),   obs_res(k), hr[k]);
            chk($sformatf("u%0d.overflow", k), obs_ovf(k), int'(ho[k]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            gsum[k] = 0; gn[k] = 0; hr[k] = 0; ho[k] = 1'b0;
            for (int j = 0; j < 3; j++) begin sv[k][j] = 1'b0; sr[k][j] = 0; so[k][j] = 1'b0; end
        end
        en = 0; last = 0; a = 0; b = 0; rst = 1;

        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(1);

        // full group
        for (int i = 0; i < 4; i++) step(1, 3, 4, 0, 0);
        idle(3);
        chk("full_res", int'(r0), 39);
        chk("full_ovf", int'(o0), 0);

        // saturation / wrap high
        for (int i = 0; i < 4; i++) step(1, 31, 31, 0, 0);
        idle(3);
        chk("sat_hi", int'(r0), 255);
        chk("sat_hi_ovf", int'(o0), 1);
        chk("wrap_hi", int'(r1), 251);
        chk("wrap_hi_ovf", int'(o1), 1);

        // early close, negative
        step(1, 1, 2, 1, 0);
        idle(3);
        chk("sat_neg", int'(r0), 0);
        chk("sat_neg_ovf", int'(o0), 1);
        chk("wrap_neg", int'(r1), 249);
        chk("wrap_neg_ovf", int'(o1), 1);

        // gaps, then back-to-back group
        step(1, 2, 5, 0, 0); idle(1);
        step(1, 1, 1, 0, 0); idle(1);
        step(1, 3, 3, 0, 0);
        step(1, 0, 7, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("gap_g1", int'(r0), 11);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        idle(3);
        chk("gap_g2", int'(r0), 0);
        chk("gap_g2_ovf", int'(o0), 1);

        // reset mid-group
        step(1, 31, 31, 0, 0);
        step(1, 31, 31, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 2, 2, 0, 0);
        idle(3);
        chk("rst_mid", int'(r0), 7);

        // single-beat groups on the ACC_LEN=1 instance
        step(1, 5, 6, 0, 0);
        step(1, 7, 7, 0, 0);
        step(1, 31, 31, 0, 0);
        idle(3);
        chk("len1_last", int'(r2), 961);

        // randomized stream
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
